systolic_feed_sched: RTL

Tile-level scheduler for the core input buffer bank (the per-lane activation/weight FIFOs feeding the systolic array). It runs one tile per command in two phases. In the load phase it accepts K upstream vectors and issues one bank write strobe per vector. In the feed phase it issues diagonally skewed per-lane read enables, so lane i drains its K entries starting i cycles after lane 0, forming the systolic wavefront. It also flags buffer underflow and bad configuration.

---
 rtl/systolic_feed_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/systolic_feed_sched.sv
// Tile scheduler for the systolic array input buffer bank: loads K vectors into
// the per-lane FIFOs, then drains them with a diagonally skewed read wavefront.
module systolic_feed_sched #(
  parameter int LANES = 8,
  parameter int DEPTH = 16,
  parameter int KW    = 5,
  parameter int TW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KW-1:0]    k_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             fifo_write,
  output logic [LANES-1:0] fifo_rd,
  input  logic [LANES-1:0] aemptys,
  input  logic [LANES-1:0] wemptys,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FEED,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    load_cnt;
  logic [TW-1:0]    t;
  logic [LANES-1:0] sched;
  logic             k_ok;
  logic             accept;
  logic             handshake;
  logic             last_load;
  logic             last_feed;
  logic             underflow;

  assign k_ok      = (k_len != '0) && (k_len <= KW'(DEPTH));
  assign accept    = (state == IDLE) && start && k_ok;
  // Handshake is derived from the state directly so the FSM block has no loop through in_ready.
  assign handshake = in_valid && (state == LOAD);
  assign last_load = handshake && (load_cnt == k_q - KW'(1));
  assign last_feed = (t == TW'(k_q) + TW'(LANES - 2));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (last_load) state_nx = FEED;
      end
      FEED: begin
        if (last_feed) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lane i is scheduled for K consecutive cycles starting at t == i.
  always_comb begin
    sched = '0;
    for (int i = 0; i < LANES; i++) begin
      sched[i] = (state == FEED) &&
                 (32'(t) >= 32'(i)) &&
                 (32'(t) <  32'(i) + 32'(k_q));
    end
  end

  assign fifo_write = handshake;
  assign fifo_rd    = sched & ~aemptys & ~wemptys;
  assign underflow  = |(sched & (aemptys | wemptys));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      load_cnt <= '0;
      t        <= '0;
      err      <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !k_ok;

      if (accept) begin
        k_q      <= k_len;
        load_cnt <= '0;
      end else if (handshake) begin
        load_cnt <= load_cnt + KW'(1);
      end

      if (last_load) begin
        t <= '0;
      end else if (state == FEED && !last_feed) begin
        t <= t + TW'(1);
      end

      // A missed read is not retried; the flag holds until the next tile launch.
      if (accept) begin
        err <= 1'b0;
      end else if (underflow) begin
        err <= 1'b1;
      end
    end
  end

  a_no_rw_overlap: assert property (@(posedge clk) disable iff (rst)
    !(fifo_write && (fifo_rd != '0)));

  a_done_only_from_feed: assert property (@(posedge clk) disable iff (rst)
    (state_nx == DONE) |-> (state == FEED));

endmodule
